// File: rtl/shift_seq_ctrl.sv
// Two-requester sequencer around one 64-bit ones-fill left shifter.
// Amounts above the shifter's native range are applied as several passes of at most MAX_STEP.

module ones_fill_shl #(
  parameter int W  = 64,
  parameter int SW = 5
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  dout
);
  // The vacated LSBs are filled with ones, so the fill mask is the complement of the shifted all-ones word.
  assign dout = (din << amt) | ~({W{1'b1}} << amt);
endmodule

module shift_seq_ctrl #(
  parameter int MAX_STEP = 31,
  parameter int AMT_W    = 7,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [AMT_W-1:0]  a_amt,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic [AMT_W-1:0]  b_amt,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id,
  output logic              busy
);
  localparam int SW = $clog2(MAX_STEP + 1);
  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(MAX_STEP);
  localparam logic [AMT_W-1:0] AMT_CLAMP = AMT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_b;
  logic [DATA_W-1:0] work;
  logic [AMT_W-1:0]  rem;
  logic              id;

  logic              grant_a, grant_b, accept;
  logic [AMT_W-1:0]  amt_sel, amt_clamp;
  logic [SW-1:0]     step;
  logic [DATA_W-1:0] shifted;

  // Round-robin: on contention the requester not granted last wins.
  assign grant_a   = a_valid && (!b_valid || last_b);
  assign grant_b   = b_valid && (!a_valid || !last_b);
  assign amt_sel   = grant_b ? b_amt : a_amt;
  assign amt_clamp = (amt_sel > AMT_CLAMP) ? AMT_CLAMP : amt_sel;
  assign step      = (rem > STEP_MAX) ? SW'(MAX_STEP) : rem[SW-1:0];

  ones_fill_shl #(.W(DATA_W), .SW(SW)) u_shl (
    .din  (work),
    .amt  (step),
    .dout (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    accept     = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_id    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        a_ready = grant_a;
        b_ready = grant_b;
        accept  = grant_a || grant_b;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: if (rem <= STEP_MAX) state_nxt = DONE;
      DONE: begin
        resp_valid = 1'b1;
        resp_data  = work;
        resp_id    = id;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
      work   <= '0;
      rem    <= '0;
      id     <= 1'b0;
    end else if (accept) begin
      last_b <= grant_b;
      work   <= grant_b ? b_data : a_data;
      rem    <= amt_clamp;
      id     <= grant_b;
    end else if (state == SHIFT) begin
      work <= shifted;
      rem  <= rem - AMT_W'(step);
    end
  end
endmodule
